// File: rtl/line_buffer_ctrl.sv
// Sequencer for the 3x3 convolver line buffer: latches frame geometry, clears the
// line FIFOs, paces pixel shifts under valid/ready and flags complete in-frame windows.
`timescale 1ns/1ps

module line_buffer_ctrl #(
    parameter int unsigned ROW_W   = 10,
    parameter int unsigned COL_W   = 10,
    parameter int unsigned MAX_ROW = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [ROW_W-1:0] cfg_row_length,
    input  logic [COL_W-1:0] cfg_col_length,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             shifting,
    output logic             line_buffer_reset,
    output logic [ROW_W-1:0] row_length,
    output logic             window_valid,
    output logic [COL_W-1:0] win_row,
    output logic [ROW_W-1:0] win_col,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_len_q, col_len_d;
    logic [ROW_W-1:0]   c_q, c_d;
    logic [COL_W-1:0]   r_q, r_d;
    logic               err_pend_q, err_pend_d;
    logic [ROW_W-1:0]   row_length_d;
    logic               window_valid_d;
    logic [COL_W-1:0]   win_row_d;
    logic [ROW_W-1:0]   win_col_d;
    logic               line_buffer_reset_d;
    logic               busy_d;
    logic               done_d;
    logic               cfg_err_d;
    logic               geom_bad;
    logic               accept;
    logic               row_last;
    logic               col_last;
    logic               abort_act;

    // Smallest useful frame is 3x3; rows longer than the FIFO depth cannot be buffered.
    assign geom_bad = (cfg_row_length < ROW_W'(3))
                   || (cfg_col_length < COL_W'(3))
                   || (32'(cfg_row_length) > MAX_ROW);

    // Abort must stall the stream in the same cycle, so the handshake stays combinational.
    assign abort_act = abort && (state_q != IDLE);
    assign in_ready  = (state_q == STREAM) && out_ready && !abort;
    assign shifting  = in_valid && in_ready;
    assign accept    = shifting;

    assign col_last = (c_q == row_length - ROW_W'(1));
    assign row_last = (r_q == col_len_q - COL_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= IDLE;
            col_len_q         <= '0;
            c_q               <= '0;
            r_q               <= '0;
            err_pend_q        <= 1'b0;
            row_length        <= '0;
            window_valid      <= 1'b0;
            win_row           <= '0;
            win_col           <= '0;
            line_buffer_reset <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            cfg_err           <= 1'b0;
        end else begin
            state_q           <= state_d;
            col_len_q         <= col_len_d;
            c_q               <= c_d;
            r_q               <= r_d;
            err_pend_q        <= err_pend_d;
            row_length        <= row_length_d;
            window_valid      <= window_valid_d;
            win_row           <= win_row_d;
            win_col           <= win_col_d;
            line_buffer_reset <= line_buffer_reset_d;
            busy              <= busy_d;
            done              <= done_d;
            cfg_err           <= cfg_err_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        col_len_d           = col_len_q;
        c_d                 = c_q;
        r_d                 = r_q;
        err_pend_d          = err_pend_q;
        row_length_d        = row_length;
        window_valid_d      = 1'b0;
        win_row_d           = win_row;
        win_col_d           = win_col;
        line_buffer_reset_d = 1'b0;
        done_d              = 1'b0;
        cfg_err_d           = 1'b0;

        if (abort_act) begin
            // Abort wins over every state action and leaves the FIFOs cleared.
            state_d             = IDLE;
            line_buffer_reset_d = 1'b1;
            err_pend_d          = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        if (geom_bad) begin
                            err_pend_d = 1'b1;
                            state_d    = DONE;
                        end else begin
                            row_length_d        = cfg_row_length;
                            col_len_d           = cfg_col_length;
                            line_buffer_reset_d = 1'b1;
                            state_d             = CLEAR;
                        end
                    end
                end
                CLEAR: begin
                    c_d     = '0;
                    r_d     = '0;
                    state_d = STREAM;
                end
                STREAM: begin
                    if (accept) begin
                        // Window is complete once two full rows and two columns precede it.
                        if ((r_q >= COL_W'(2)) && (c_q >= ROW_W'(2))) begin
                            window_valid_d = 1'b1;
                            win_row_d      = r_q - COL_W'(2);
                            win_col_d      = c_q - ROW_W'(2);
                        end
                        if (col_last) begin
                            c_d = '0;
                            if (row_last) begin
                                state_d = FLUSH;
                            end else begin
                                r_d = r_q + COL_W'(1);
                            end
                        end else begin
                            c_d = c_q + ROW_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    state_d = DONE;
                end
                DONE: begin
                    done_d     = 1'b1;
                    cfg_err_d  = err_pend_q;
                    err_pend_d = 1'b0;
                    state_d    = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed self-checking bench for line_buffer_ctrl: full frames, stalls, illegal
// geometry, abort/restart and asynchronous reset mid-stream.
`timescale 1ns/1ps

module tb_line_buffer_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [9:0] cfg_row_length;
    logic [9:0] cfg_col_length;
    logic       in_valid;
    logic       in_ready;
    logic       out_ready;
    logic       shifting;
    logic       line_buffer_reset;
    logic [9:0] row_length;
    logic       window_valid;
    logic [9:0] win_row;
    logic [9:0] win_col;
    logic       busy;
    logic       done;
    logic       cfg_err;

    int checks   = 0;
    int failures = 0;

    int cyc, n_shift, n_lbr, lbr_cyc, n_done, done_cyc, n_err;
    int bad_shift, bad_strobe;
    logic busy_at_done;
    logic prev_acc;
    logic [9:0] sq_row[$];
    logic [9:0] sq_col[$];
    int         sq_at[$];

    line_buffer_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .abort             (abort),
        .cfg_row_length    (cfg_row_length),
        .cfg_col_length    (cfg_col_length),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .out_ready         (out_ready),
        .shifting          (shifting),
        .line_buffer_reset (line_buffer_reset),
        .row_length        (row_length),
        .window_valid      (window_valid),
        .win_row           (win_row),
        .win_col           (win_col),
        .busy              (busy),
        .done              (done),
        .cfg_err           (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        cyc = 0; n_shift = 0; n_lbr = 0; lbr_cyc = -1; n_done = 0; done_cyc = -1;
        n_err = 0; bad_shift = 0; bad_strobe = 0; busy_at_done = 1'bx; prev_acc = 1'b0;
        sq_row.delete(); sq_col.delete(); sq_at.delete();
    endtask

    // Inputs are set at posedge+1; outputs are sampled at posedge+3.
    task automatic tick();
        #2;
        if (window_valid === 1'b1) begin
            if (!prev_acc) bad_strobe++;
            sq_row.push_back(win_row);
            sq_col.push_back(win_col);
            sq_at.push_back(n_shift);
        end
        if (shifting === 1'b1) begin
            n_shift++;
            if (!(in_valid && out_ready)) bad_shift++;
        end
        if (line_buffer_reset === 1'b1) begin
            n_lbr++;
            lbr_cyc = cyc;
        end
        if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
            busy_at_done = busy;
        end
        if (cfg_err === 1'b1) n_err++;
        prev_acc = (shifting === 1'b1);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int w, input int h, input int mode, input int abort_at,
                             input bit illegal);
        int  stall_left;
        bit  stalled;
        bit  aborted;
        int  post;
        int  nwin;
        clear_stats();
        stall_left = 0; stalled = 0; aborted = 0; post = 0;
        cfg_row_length = 10'(w);
        cfg_col_length = 10'(h);
        start = 1'b1; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        start = 1'b0;
        // Geometry is latched; later cfg changes must be ignored.
        cfg_row_length = 10'(w + 1);
        cfg_col_length = 10'(h + 2);
        for (int i = 0; i < 300; i++) begin
            if (mode == 1 && !stalled && n_shift == 14) begin
                stalled = 1; stall_left = 3;
            end
            in_valid  = (mode == 1) ? ((i % 2) == 0) : 1'b1;
            out_ready = (stall_left == 0);
            if (abort_at >= 0 && !aborted && n_shift == abort_at) begin
                abort = 1'b1;
                #1;
                chk("abort_in_ready_drop", 32'(in_ready), 0);
                chk("abort_no_shift", 32'(shifting), 0);
                aborted = 1;
                tick();
                abort = 1'b0;
            end else begin
                tick();
            end
            if (stall_left > 0) stall_left--;
            if (aborted || n_done > 0) begin
                post++;
                if (post >= 5) break;
            end
        end
        in_valid = 1'b0;

        if (abort_at >= 0) begin
            chk("abort_no_done", 32'(n_done), 0);
            chk("abort_lbr_pulses", 32'(n_lbr), 2);
            chk("abort_shift_count", 32'(n_shift), 32'(abort_at));
            chk("abort_busy_low", 32'(busy), 0);
            chk("abort_wv_low", 32'(window_valid), 0);
        end else if (illegal) begin
            chk("bad_done_count", 32'(n_done), 1);
            chk("bad_done_cycle", 32'(done_cyc), 2);
            chk("bad_cfg_err", 32'(n_err), 1);
            chk("bad_no_shift", 32'(n_shift), 0);
            chk("bad_no_lbr", 32'(n_lbr), 0);
        end else begin
            nwin = (w - 2) * (h - 2);
            chk("frame_done_count", 32'(n_done), 1);
            chk("frame_cfg_err", 32'(n_err), 0);
            chk("frame_shifts", 32'(n_shift), 32'(w * h));
            chk("frame_lbr_count", 32'(n_lbr), 1);
            chk("frame_lbr_cycle", 32'(lbr_cyc), 1);
            chk("frame_strobes", 32'(sq_row.size()), 32'(nwin));
            chk("frame_bad_shift", 32'(bad_shift), 0);
            chk("frame_stall_strobe", 32'(bad_strobe), 0);
            chk("frame_busy_at_done", 32'(busy_at_done), 0);
            chk("frame_row_length", 32'(row_length), 32'(w));
            chk("frame_win_row_hold", 32'(win_row), 32'(h - 3));
            chk("frame_win_col_hold", 32'(win_col), 32'(w - 3));
            if (mode == 0) chk("frame_done_cycle", 32'(done_cyc), 32'(w * h + 4));
            for (int k = 0; k < sq_row.size() && k < nwin; k++) begin
                chk("strobe_row", 32'(sq_row[k]), 32'(k / (w - 2)));
                chk("strobe_col", 32'(sq_col[k]), 32'(k % (w - 2)));
                chk("strobe_after_pixel", 32'(sq_at[k]),
                    32'((k / (w - 2) + 2) * w + (k % (w - 2)) + 3));
            end
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cfg_row_length = '0; cfg_col_length = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_lbr", 32'(line_buffer_reset), 0);
        chk("rst_row_length", 32'(row_length), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_window_valid", 32'(window_valid), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_frame(5, 4, 0, -1, 1'b0);
        run_frame(5, 4, 1, -1, 1'b0);
        run_frame(2, 8, 0, -1, 1'b1);
        run_frame(600, 8, 0, -1, 1'b1);
        run_frame(3, 3, 0, -1, 1'b0);
        run_frame(5, 4, 0, 10, 1'b0);
        run_frame(5, 4, 0, -1, 1'b0);

        // start together with abort in IDLE: nothing happens.
        clear_stats();
        cfg_row_length = 10'd5; cfg_col_length = 10'd4;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        repeat (3) tick();
        chk("start_abort_idle_busy", 32'(busy), 0);
        chk("start_abort_idle_lbr", 32'(n_lbr), 0);

        // Asynchronous reset in the middle of streaming.
        clear_stats();
        cfg_row_length = 10'd5; cfg_col_length = 10'd4;
        start = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        repeat (15) tick();
        chk("midrst_pre_busy", 32'(busy), 1);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_in_ready", 32'(in_ready), 0);
        chk("midrst_shifting", 32'(shifting), 0);
        chk("midrst_window_valid", 32'(window_valid), 0);
        chk("midrst_win_row", 32'(win_row), 0);
        chk("midrst_win_col", 32'(win_col), 0);
        chk("midrst_row_length", 32'(row_length), 0);
        chk("midrst_lbr", 32'(line_buffer_reset), 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_frame(5, 4, 0, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
- Sequencer for the 3x3 convolver line buffer.
- Latches frame geometry on start and clears the line FIFOs.
- Drives `shifting` per accepted pixel under a valid/ready stream handshake.
- Flags, with window coordinates, each cycle on which out1..out9 hold a complete, in-frame 3x3 window for the downstream MAC array.

Parameters:
- ROW_W, 10, width of row_length / column counter (matches `ADDR_FIFO`)
- COL_W, 10, width of col_length / row counter
- MAX_ROW, 512, largest legal row_length (line FIFO depth + 3)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin frame; sampled in IDLE only
- abort  in  1  synchronous abort; return to IDLE
- cfg_row_length  in  ROW_W  pixels per row (W)
- cfg_col_length  in  COL_W  rows per frame (H)
- in_valid  in  1  upstream pixel present on line buffer inp
- in_ready  out  1  pixel accepted when in_valid && in_ready
- out_ready  in  1  downstream able to take a window next cycle
- shifting  out  1  to line buffer; = in_valid && in_ready (combinational)
- line_buffer_reset  out  1  to line buffer; registered, one-cycle pulse
- row_length  out  ROW_W  to line buffer; latched W, held during frame
- window_valid  out  1  registered strobe: out1..out9 form a valid window
- win_row  out  COL_W  output row index of window (r-2)
- win_col  out  ROW_W  output column index of window (c-2)
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at frame end
- cfg_err  out  1  one-cycle pulse with done on illegal geometry

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; counters and latched row_length 0.
- States: IDLE, CLEAR, STREAM, FLUSH, DONE.
- IDLE, start=1:
  - W<3, H<3 or W>MAX_ROW: go to DONE with cfg_err set. No line_buffer_reset, no shifting.
  - Otherwise latch W into row_length and H, assert line_buffer_reset for the next cycle, go to CLEAR.
- CLEAR: line_buffer_reset=1 for exactly one cycle; c=r=0; go to STREAM.
- STREAM:
  - in_ready = out_ready; all other states in_ready=0.
  - Per accepted pixel at (r,c): c increments, wraps to 0 at W-1 and increments r.
  - If r>=2 and c>=2, next cycle window_valid=1, win_row=r-2, win_col=c-2. Otherwise window_valid=0.
  - win_row/win_col hold their last values when window_valid=0.
  - Stall (in_valid=0 or out_ready=0): counters hold, no shift, window_valid=0 next cycle.
  - Accepting pixel (H-1,W-1) goes to FLUSH.
- FLUSH: one cycle, carries the final window_valid strobe; go to DONE.
- DONE: done=1 one cycle (cfg_err too if applicable); go to IDLE.
- Frame totals:
  - Exactly W*H shifts.
  - (W-2)*(H-2) window_valid strobes, in raster order.
  - First strobe follows pixel index 2W+2; last follows pixel W*H-1.
- Downstream contract: window_valid is a strobe. Since shifting requires out_ready in the previous cycle, downstream must capture it unconditionally.
- start while busy: ignored.
- abort (any non-IDLE state, priority over everything):
  - next state IDLE, in_ready=0 immediately (combinational);
  - one-cycle line_buffer_reset pulse next cycle, window_valid cleared, no done.
  - abort in IDLE: no effect.
- start and abort both high in IDLE: abort wins, start ignored.
- cfg_* changes during a frame: no effect; latched values used.
- rst low mid-frame: immediate return to reset values; line buffer contents undefined until next CLEAR.

Test Plan:
- W=5,H=4, in_valid=1, out_ready=1 continuously:
  - line_buffer_reset one cycle, then 20 shifts.
  - 6 window_valid strobes at (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); first strobe in the cycle after the 13th accepted pixel.
  - done one cycle after FLUSH; busy low after.
- Same frame, in_valid toggled 1/0 each cycle and out_ready low for 3 cycles at pixel 14:
  - shifting only on in_valid && out_ready; still 20 shifts and 6 strobes.
  - No strobe during stall cycles.
- W=2,H=8 and W=600,H=8 (MAX_ROW=512): done+cfg_err pulse two cycles after start; no shifting, no line_buffer_reset.
- W=3,H=3: exactly 1 strobe, win_row=0, win_col=0, after the 9th pixel.
- abort at pixel 10 of a 5x4 frame: in_ready drops that cycle; line_buffer_reset pulse; IDLE; no done. Restart with 5x4 completes normally with 6 strobes.
- rst asserted mid-STREAM: all outputs 0 asynchronously. start after release runs a full frame correctly.
